simt_issue_ctrl: RTL and testbench
==================================

// Module: simt_issue_ctrl
// PURPOSE
// Registered, parametrised SIMT issue stage between the warp scheduler and operand collection.
// Issues one packet per cycle under a valid/ready handshake and detects reconvergence (PC == stack-top RPC).
// Tracks per-warp liveness (EXIT) and a CTA-wide SYNC barrier. Feeds stall/release masks back to the scheduler.
// PARAMETERS
// NUM_WARP      8   warps per core
// NUM_WARP_LOG  3   clog2(NUM_WARP)
// SIZE_CORE     8   lanes (active-mask width)
// SIZE_PC       32  PC / RPC width
// PKT_W         256 decoded-packet width; current PC sits at [3*SIZE_PC-1:2*SIZE_PC]
// SYNC_BIT      200 packet bit index of the SYNC flag
// EXIT_BIT      201 packet bit index of the EXIT flag
// PORTS
// clk             in   1             clock
// reset           in   1             synchronous reset, active-low
// launch_i        in   1             load live mask (CTA start)
// launchMask_i    in   NUM_WARP      warps present in the CTA
// selWarp_i       in   NUM_WARP_LOG  scheduler-selected warp
// selValid_i      in   1             selected packet valid
// selReady_o      out  1             stage can accept a packet this cycle
// selPacket_i     in   PKT_W         decoded packet
// activeMask_i    in   SIZE_CORE     stack-top active mask of selWarp_i
// topRPC_i        in   SIZE_PC       stack-top reconvergence PC of selWarp_i
// issWarp_o       out  NUM_WARP_LOG  registered warp id
// issValid_o      out  1             registered packet valid
// issReady_i      in   1             downstream accepts
// issPacket_o     out  PKT_W         registered packet
// issMask_o       out  SIZE_CORE     lane mask; 0 on reconvergence
// reconv_o        out  1             registered: issued packet hit its RPC (pop stack)
// warpStall_o     out  NUM_WARP      warps parked at the barrier
// barRelease_o    out  1             one-cycle pulse: barrier released
// allExited_o     out  1             live mask == 0 after a launch
// protoErr_o      out  1             sticky: SYNC/EXIT from a non-live or parked warp
// issueCnt_o      out  32            issued-packet counter (wraps)
// BEHAVIOUR
// - Reset (reset==0 at posedge): every output 0, live/arrived masks 0, counter 0, protoErr clear.
// - Handshake: selReady_o = !issValid_o | issReady_i. Accept = selValid_i & selReady_o; 1-cycle latency.
// - Output regs hold while issValid_o & !issReady_i. On fire without a new accept, issValid_o drops to 0.
// - Reconv: on accept, if PC == topRPC_i, reconv_o=1 and issMask_o=0; else reconv_o=0, issMask_o=activeMask_i.
// - reconv_o is qualified by issValid_o; downstream samples it only on issue fire.
// - issueCnt_o increments on every output fire (issValid_o & issReady_i), mod 2^32.
// - EXIT (accepted packet, EXIT_BIT set): clear live[w] and arrived[w] at accept.
// - SYNC (accepted, SYNC_BIT set): set arrived[w]. warpStall_o = arrived.
// - Release: when arrived != 0 and arrived == live (same-cycle next-state values), clear arrived next edge.
//   barRelease_o pulses for exactly that cycle.
// - Simultaneous: an EXIT from the last non-arrived warp completes the barrier; release occurs in the same update.
// - launch_i: live <= launchMask_i, arrived <= 0, allExited_o <= 0. launch_i wins over a same-cycle accept.
// - allExited_o is set when live becomes 0 through an EXIT; it stays set until launch_i or reset.
// - Error: SYNC/EXIT from a warp with live==0, or SYNC from an arrived warp, is ignored for state and sets protoErr_o.
//   The packet is still issued.
// - Mid-operation reset: pending packet dropped, barrier abandoned, no release pulse.
// STRUCTURE
// - Shared package (GPGPUParam): NUM_WARP, SIZE_CORE, SIZE_PC, packet field offsets (SYNC/EXIT/PC).
// - One sub-module: simt_barrier_track (live/arrived masks, release, allExited, protoErr).
// - Datapath register and reconv compare stay in the top module.
// TESTING
// - Reconv: PC=0x40, topRPC=0x40, mask=0xFF -> next cycle issValid=1, reconv_o=1, issMask_o=0x00.
// - Non-reconv: PC=0x44, topRPC=0x40, mask=0x0F -> issMask_o=0x0F, reconv_o=0.
// - Backpressure: issReady_i=0 for 3 cycles -> outputs stable, selReady_o=0; counter unchanged until fire.
// - Barrier: launchMask=0x0F; SYNC from warps 0-3 -> warpStall_o 0x1,0x3,0x7, then barRelease_o pulse and stall 0x0.
// - Exit-completes-barrier: live=0x3, SYNC w0, EXIT w1 -> release pulse; live=0x1.
//   EXIT w0 -> allExited_o=1.
// - Error and reset: SYNC from unlaunched w5 -> protoErr_o=1, state unchanged.
//   reset=0 mid-stall -> all outputs 0, no release pulse.

Source files
------------

// File: rtl/simt_issue_ctrl_pkg.sv
// Shared parameters, packet field offsets and barrier event encoding for the SIMT issue stage.
package simt_issue_ctrl_pkg;

  localparam int NUM_WARP     = 8;
  localparam int NUM_WARP_LOG = 3;
  localparam int SIZE_CORE    = 8;
  localparam int SIZE_PC      = 32;
  localparam int PKT_W        = 256;
  localparam int SYNC_BIT     = 200;
  localparam int EXIT_BIT     = 201;
  localparam int PC_LSB       = 2 * SIZE_PC;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_SYNC = 2'd1,
    EV_EXIT = 2'd2
  } bar_ev_e;

  // EXIT outranks SYNC when a packet carries both flags.
  function automatic bar_ev_e decode_ev(input logic sync_f, input logic exit_f);
    bar_ev_e ev;
    if (exit_f) begin
      ev = EV_EXIT;
    end else if (sync_f) begin
      ev = EV_SYNC;
    end else begin
      ev = EV_NONE;
    end
    return ev;
  endfunction

endpackage

// File: rtl/simt_barrier_track.sv
// Per-warp liveness and CTA-wide SYNC barrier: live/arrived masks, release pulse,
// all-exited flag and sticky protocol error.
module simt_barrier_track
  import simt_issue_ctrl_pkg::*;
#(
  parameter int NW  = NUM_WARP,
  parameter int NWL = NUM_WARP_LOG
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           launch_i,
  input  logic [NW-1:0]  launchMask_i,
  input  logic           evValid_i,
  input  logic [NWL-1:0] warp_i,
  input  bar_ev_e        ev_i,
  output logic [NW-1:0]  warpStall_o,
  output logic           barRelease_o,
  output logic           allExited_o,
  output logic           protoErr_o
);

  logic [NW-1:0] live_q, live_d, arr_q, arr_d;
  logic          rel_q, rel_d, allx_q, allx_d, err_q, err_d;

  // Next-state for masks; release is judged on the post-update masks so an EXIT can complete the barrier.
  always_comb begin
    live_d = live_q;
    arr_d  = arr_q;
    rel_d  = 1'b0;
    allx_d = allx_q;
    err_d  = err_q;
    if (launch_i) begin
      live_d = launchMask_i;
      arr_d  = '0;
      allx_d = 1'b0;
    end else if (evValid_i) begin
      case (ev_i)
        EV_SYNC: begin
          if (!live_q[warp_i] || arr_q[warp_i]) begin
            err_d = 1'b1;
          end else begin
            arr_d[warp_i] = 1'b1;
          end
        end
        EV_EXIT: begin
          if (!live_q[warp_i]) begin
            err_d = 1'b1;
          end else begin
            live_d[warp_i] = 1'b0;
            arr_d[warp_i]  = 1'b0;
            allx_d = (live_d == '0) ? 1'b1 : allx_q;
          end
        end
        default: begin
          err_d = err_q;
        end
      endcase
    end else begin
      err_d = err_q;
    end
    if ((arr_d != '0) && (arr_d == live_d)) begin
      arr_d = '0;
      rel_d = 1'b1;
    end else begin
      rel_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      live_q <= '0;
      arr_q  <= '0;
      rel_q  <= 1'b0;
      allx_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      live_q <= live_d;
      arr_q  <= arr_d;
      rel_q  <= rel_d;
      allx_q <= allx_d;
      err_q  <= err_d;
    end
  end

  assign warpStall_o  = arr_q;
  assign barRelease_o = rel_q;
  assign allExited_o  = allx_q;
  assign protoErr_o   = err_q;

endmodule

// File: rtl/simt_issue_ctrl.sv
// SIMT issue stage: registered valid/ready packet slot with reconvergence detect,
// issue counter, and barrier/liveness tracking fed back to the scheduler.
module simt_issue_ctrl
  import simt_issue_ctrl_pkg::*;
#(
  parameter int NW  = NUM_WARP,
  parameter int NWL = NUM_WARP_LOG,
  parameter int NC  = SIZE_CORE,
  parameter int PCW = SIZE_PC,
  parameter int PW  = PKT_W,
  parameter int SB  = SYNC_BIT,
  parameter int EB  = EXIT_BIT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           launch_i,
  input  logic [NW-1:0]  launchMask_i,
  input  logic [NWL-1:0] selWarp_i,
  input  logic           selValid_i,
  output logic           selReady_o,
  input  logic [PW-1:0]  selPacket_i,
  input  logic [NC-1:0]  activeMask_i,
  input  logic [PCW-1:0] topRPC_i,
  output logic [NWL-1:0] issWarp_o,
  output logic           issValid_o,
  input  logic           issReady_i,
  output logic [PW-1:0]  issPacket_o,
  output logic [NC-1:0]  issMask_o,
  output logic           reconv_o,
  output logic [NW-1:0]  warpStall_o,
  output logic           barRelease_o,
  output logic           allExited_o,
  output logic           protoErr_o,
  output logic [31:0]    issueCnt_o
);

  localparam int PCL = 2 * PCW;

  logic           valid_q, valid_d, reconv_q, reconv_d;
  logic [NWL-1:0] warp_q, warp_d;
  logic [PW-1:0]  pkt_q, pkt_d;
  logic [NC-1:0]  mask_q, mask_d;
  logic [31:0]    cnt_q, cnt_d;
  logic           accept, fire, hit;
  bar_ev_e        ev;

  assign selReady_o = !valid_q | issReady_i;
  assign accept     = selValid_i & selReady_o;
  assign fire       = valid_q & issReady_i;
  assign hit        = (selPacket_i[PCL +: PCW] == topRPC_i);
  assign ev         = decode_ev(selPacket_i[SB], selPacket_i[EB]);

  // Output slot next-state: load on accept, drain on fire, otherwise hold.
  always_comb begin
    valid_d  = valid_q;
    warp_d   = warp_q;
    pkt_d    = pkt_q;
    mask_d   = mask_q;
    reconv_d = reconv_q;
    if (accept) begin
      valid_d  = 1'b1;
      warp_d   = selWarp_i;
      pkt_d    = selPacket_i;
      reconv_d = hit;
      mask_d   = hit ? '0 : activeMask_i;
    end else if (fire) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (fire) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      warp_q   <= '0;
      pkt_q    <= '0;
      mask_q   <= '0;
      reconv_q <= 1'b0;
      cnt_q    <= 32'd0;
    end else begin
      valid_q  <= valid_d;
      warp_q   <= warp_d;
      pkt_q    <= pkt_d;
      mask_q   <= mask_d;
      reconv_q <= reconv_d;
      cnt_q    <= cnt_d;
    end
  end

  simt_barrier_track #(.NW(NW), .NWL(NWL)) u_bar (
    .clk          (clk),
    .reset        (reset),
    .launch_i     (launch_i),
    .launchMask_i (launchMask_i),
    .evValid_i    (accept),
    .warp_i       (selWarp_i),
    .ev_i         (ev),
    .warpStall_o  (warpStall_o),
    .barRelease_o (barRelease_o),
    .allExited_o  (allExited_o),
    .protoErr_o   (protoErr_o)
  );

  assign issValid_o  = valid_q;
  assign issWarp_o   = warp_q;
  assign issPacket_o = pkt_q;
  assign issMask_o   = mask_q;
  assign reconv_o    = reconv_q;
  assign issueCnt_o  = cnt_q;

endmodule

// File: tb/tb_simt_issue_ctrl.sv
// Directed, table-driven bench for simt_issue_ctrl: issue/reconv vectors plus
// hand-written backpressure, barrier, exit, error and reset sequences.
module tb_simt_issue_ctrl;

  logic         clk = 1'b0;
  logic         reset, launch_i, selValid_i, issReady_i;
  logic [7:0]   launchMask_i, activeMask_i;
  logic [2:0]   selWarp_i;
  logic [255:0] selPacket_i;
  logic [31:0]  topRPC_i;
  logic         selReady_o, issValid_o, reconv_o, barRelease_o, allExited_o, protoErr_o;
  logic [2:0]   issWarp_o;
  logic [255:0] issPacket_o;
  logic [7:0]   issMask_o, warpStall_o;
  logic [31:0]  issueCnt_o;

  int n_chk = 0;
  int n_fail = 0;

  simt_issue_ctrl dut (
    .clk(clk), .reset(reset), .launch_i(launch_i), .launchMask_i(launchMask_i),
    .selWarp_i(selWarp_i), .selValid_i(selValid_i), .selReady_o(selReady_o),
    .selPacket_i(selPacket_i), .activeMask_i(activeMask_i), .topRPC_i(topRPC_i),
    .issWarp_o(issWarp_o), .issValid_o(issValid_o), .issReady_i(issReady_i),
    .issPacket_o(issPacket_o), .issMask_o(issMask_o), .reconv_o(reconv_o),
    .warpStall_o(warpStall_o), .barRelease_o(barRelease_o), .allExited_o(allExited_o),
    .protoErr_o(protoErr_o), .issueCnt_o(issueCnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic vld; logic rdy; logic [2:0] w; logic [31:0] pc; logic [31:0] rpc; logic [7:0] mask;
    logic e_valid; logic [2:0] e_warp; logic [7:0] e_mask; logic e_reconv; logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [255:0] mkpkt(input logic [31:0] pc, input logic s, input logic e);
    logic [255:0] p;
    p = {8{pc ^ 32'h5A5A_0000}};
    p[95:64] = pc;
    p[200] = s;
    p[201] = e;
    return p;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic r, input logic [2:0] w, input logic [31:0] pc,
                       input logic [31:0] rpc, input logic [7:0] m, input logic s, input logic e);
    selValid_i = v; issReady_i = r; selWarp_i = w; topRPC_i = rpc; activeMask_i = m;
    selPacket_i = mkpkt(pc, s, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] w, input logic s, input logic e);
    drive(1'b1, 1'b1, w, 32'h1000 + {29'd0, w}, 32'h0, 8'hFF, s, e);
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0);
    tick();
  endtask

  task automatic launch(input logic [7:0] m);
    launch_i = 1'b1; launchMask_i = m;
    drive(1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0);
    tick();
    launch_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " issValid"}, {255'd0, issValid_o}, 256'd0);
    chk({tag, " issWarp"}, {253'd0, issWarp_o}, 256'd0);
    chk({tag, " issPacket"}, issPacket_o, 256'd0);
    chk({tag, " issMask"}, {248'd0, issMask_o}, 256'd0);
    chk({tag, " reconv"}, {255'd0, reconv_o}, 256'd0);
    chk({tag, " warpStall"}, {248'd0, warpStall_o}, 256'd0);
    chk({tag, " barRelease"}, {255'd0, barRelease_o}, 256'd0);
    chk({tag, " allExited"}, {255'd0, allExited_o}, 256'd0);
    chk({tag, " protoErr"}, {255'd0, protoErr_o}, 256'd0);
    chk({tag, " issueCnt"}, {224'd0, issueCnt_o}, 256'd0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 3'd2, 32'h40,       32'h40,       8'hFF, 1'b1, 3'd2, 8'h00, 1'b1, 32'd0};
    tbl[1] = '{1'b1, 1'b1, 3'd3, 32'h44,       32'h40,       8'h0F, 1'b1, 3'd3, 8'h0F, 1'b0, 32'd1};
    tbl[2] = '{1'b0, 1'b1, 3'd6, 32'h99,       32'h99,       8'hFF, 1'b0, 3'd3, 8'h0F, 1'b0, 32'd2};
    tbl[3] = '{1'b1, 1'b0, 3'd1, 32'h100,      32'h200,      8'hA5, 1'b1, 3'd1, 8'hA5, 1'b0, 32'd2};
    tbl[4] = '{1'b1, 1'b1, 3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h80, 1'b1, 3'd7, 8'h00, 1'b1, 32'd3};
    tbl[5] = '{1'b0, 1'b1, 3'd0, 32'h0,        32'h1,        8'h00, 1'b0, 3'd7, 8'h00, 1'b1, 32'd4};

    reset = 1'b0; launch_i = 1'b0; launchMask_i = 8'h00;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0);
    tick(); tick();
    chk_all_zero("reset");
    reset = 1'b1;

    // Issue path vectors
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].vld, tbl[i].rdy, tbl[i].w, tbl[i].pc, tbl[i].rpc, tbl[i].mask, 1'b0, 1'b0);
      tick();
      chk($sformatf("v%0d issValid", i), {255'd0, issValid_o}, {255'd0, tbl[i].e_valid});
      chk($sformatf("v%0d issWarp", i), {253'd0, issWarp_o}, {253'd0, tbl[i].e_warp});
      chk($sformatf("v%0d issMask", i), {248'd0, issMask_o}, {248'd0, tbl[i].e_mask});
      chk($sformatf("v%0d reconv", i), {255'd0, reconv_o}, {255'd0, tbl[i].e_reconv});
      chk($sformatf("v%0d issueCnt", i), {224'd0, issueCnt_o}, {224'd0, tbl[i].e_cnt});
      if (tbl[i].vld) chk($sformatf("v%0d issPacket", i), issPacket_o, mkpkt(tbl[i].pc, 1'b0, 1'b0));
    end

    // Backpressure: packet A held for 3 stalled cycles while B waits
    drive(1'b1, 1'b0, 3'd4, 32'h80, 32'h0, 8'h33, 1'b0, 1'b0);
    tick();
    chk("bp load A", issPacket_o, mkpkt(32'h80, 1'b0, 1'b0));
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 3'd5, 32'h84, 32'h0, 8'hCC, 1'b0, 1'b0);
      #1;
      chk($sformatf("bp%0d selReady", c), {255'd0, selReady_o}, 256'd0);
      tick();
      chk($sformatf("bp%0d packet", c), issPacket_o, mkpkt(32'h80, 1'b0, 1'b0));
      chk($sformatf("bp%0d mask", c), {248'd0, issMask_o}, {248'd0, 8'h33});
      chk($sformatf("bp%0d issueCnt", c), {224'd0, issueCnt_o}, 256'd4);
    end
    drive(1'b1, 1'b1, 3'd5, 32'h84, 32'h0, 8'hCC, 1'b0, 1'b0);
    #1;
    chk("bp release selReady", {255'd0, selReady_o}, 256'd1);
    tick();
    chk("bp fire A cnt", {224'd0, issueCnt_o}, 256'd5);
    chk("bp load B", issPacket_o, mkpkt(32'h84, 1'b0, 1'b0));
    chk("bp B warp", {253'd0, issWarp_o}, 256'd5);
    idle();
    chk("bp fire B cnt", {224'd0, issueCnt_o}, 256'd6);
    chk("bp drained", {255'd0, issValid_o}, 256'd0);

    // Barrier over four warps
    launch(8'h0F);
    chk("bar launch stall", {248'd0, warpStall_o}, 256'd0);
    issue(3'd0, 1'b1, 1'b0);
    chk("bar w0 stall", {248'd0, warpStall_o}, 256'h1);
    issue(3'd1, 1'b1, 1'b0);
    chk("bar w1 stall", {248'd0, warpStall_o}, 256'h3);
    issue(3'd2, 1'b1, 1'b0);
    chk("bar w2 stall", {248'd0, warpStall_o}, 256'h7);
    chk("bar w2 no release", {255'd0, barRelease_o}, 256'd0);
    issue(3'd3, 1'b1, 1'b0);
    chk("bar w3 stall", {248'd0, warpStall_o}, 256'h0);
    chk("bar w3 release", {255'd0, barRelease_o}, 256'd1);
    idle();
    chk("bar pulse ends", {255'd0, barRelease_o}, 256'd0);

    // EXIT of the last non-arrived warp completes the barrier
    launch(8'h03);
    issue(3'd0, 1'b1, 1'b0);
    chk("ex sync w0", {248'd0, warpStall_o}, 256'h1);
    issue(3'd1, 1'b0, 1'b1);
    chk("ex release", {255'd0, barRelease_o}, 256'd1);
    chk("ex stall clear", {248'd0, warpStall_o}, 256'h0);
    chk("ex not all", {255'd0, allExited_o}, 256'd0);
    issue(3'd0, 1'b0, 1'b1);
    chk("ex allExited", {255'd0, allExited_o}, 256'd1);
    chk("ex no release", {255'd0, barRelease_o}, 256'd0);
    idle();
    chk("ex allExited held", {255'd0, allExited_o}, 256'd1);
    chk("ex no protoErr", {255'd0, protoErr_o}, 256'd0);

    // Protocol error from an unlaunched warp
    launch(8'h0F);
    chk("err launch clears allExited", {255'd0, allExited_o}, 256'd0);
    issue(3'd0, 1'b1, 1'b0);
    issue(3'd1, 1'b1, 1'b0);
    issue(3'd5, 1'b1, 1'b0);
    chk("err protoErr", {255'd0, protoErr_o}, 256'd1);
    chk("err stall unchanged", {248'd0, warpStall_o}, 256'h3);
    chk("err still issued", {255'd0, issValid_o}, 256'd1);
    chk("err issued warp", {253'd0, issWarp_o}, 256'd5);

    // Reset while warps are parked: nothing survives, no release
    reset = 1'b0;
    drive(1'b1, 1'b1, 3'd2, 32'h2000, 32'h0, 8'hFF, 1'b1, 1'b0);
    tick();
    chk_all_zero("midreset");
    reset = 1'b1;
    idle();
    chk("post reset release", {255'd0, barRelease_o}, 256'd0);
    chk("post reset stall", {248'd0, warpStall_o}, 256'd0);
    issue(3'd1, 1'b1, 1'b0);
    chk("post reset live cleared", {255'd0, protoErr_o}, 256'd1);
    chk("post reset no stall", {248'd0, warpStall_o}, 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
